// File: rtl/nourishment_pkg.sv
// Shared definitions for the nourishment controller.
//   feed_state_e : FSM encoding (fed / empty / starved)
//   Level*       : value thresholds separating the four nourishment levels
//   level_of()   : quantise an 8-bit value to its 2-bit level
package nourishment_pkg;

    typedef enum logic [1:0] {
        StFed     = 2'd0,
        StEmpty   = 2'd1,
        StStarved = 2'd2
    } feed_state_e;

    localparam logic [7:0] LevelQ1 = 8'd64;
    localparam logic [7:0] LevelQ2 = 8'd128;
    localparam logic [7:0] LevelQ3 = 8'd192;

    function automatic logic [1:0] level_of(input logic [7:0] v);
        if (v >= LevelQ3) begin
            return 2'd3;
        end else if (v >= LevelQ2) begin
            return 2'd2;
        end else if (v >= LevelQ1) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

endpackage

// File: rtl/nourishment_controller_if.sv
// Request/status bundle of the nourishment controller.
//   ena, inc, dec, fast, setval : regulator requests (master -> slave)
//   value, nourishment_level,
//   step, starving              : controller status (slave -> master)
interface nourishment_controller_if;

    logic       ena;
    logic       inc;
    logic       dec;
    logic       fast;
    logic       setval;
    logic [7:0] value;
    logic [1:0] nourishment_level;
    logic       step;
    logic       starving;

    modport master (
        output ena, inc, dec, fast, setval,
        input  value, nourishment_level, step, starving
    );

    modport slave (
        input  ena, inc, dec, fast, setval,
        output value, nourishment_level, step, starving
    );

endinterface

// File: rtl/rate_prescaler.sv
// 5-bit rate prescaler; emits a tick when the count reaches div_i-1.
//   clk, rst_n : clock, synchronous active-low reset
//   run_i      : advance the count this cycle
//   clr_i      : discard the partial count (wins over run_i)
//   div_i      : period in cycles, sampled every cycle
//   tick_o     : count wraps this cycle (combinational, same-cycle step)
module rate_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic       clr_i,
    input  logic [4:0] div_i,
    output logic       tick_o
);

    logic [4:0] count_q, count_d;

    // >= rather than == so a drop of the divisor mid-count fires at once.
    assign tick_o = run_i && !clr_i && (count_q >= div_i - 5'd1);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 5'd0;
        end else if (run_i) begin
            count_d = tick_o ? 5'd0 : count_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 5'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/nourishment_controller.sv
// Nourishment controller: rate-limited saturating value driven by inc/dec
// requests, with a fed/empty/starved supervisor.
//   clk, rst_n : clock, synchronous active-low reset (overrides ena)
//   bus        : slave side of nourishment_controller_if; all outputs registered
module nourishment_controller
    import nourishment_pkg::*;
#(
    parameter int unsigned SLOW_DIV     = 16,
    parameter int unsigned FAST_DIV     = 4,
    parameter logic [7:0]  SET_VALUE    = 8'h80,
    parameter int unsigned STARVE_STEPS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nourishment_controller_if.slave   bus
);

    localparam int unsigned CntW = $clog2(STARVE_STEPS + 1);

    logic [7:0]     value_q, value_d;
    logic           step_q, step_d;
    logic           starving_q;
    feed_state_e    state_q, state_d;
    logic [CntW-1:0] empty_cnt_q, empty_cnt_d;

    logic       one_req;
    logic       load;
    logic       run;
    logic       clr;
    logic       tick;
    logic       dec_at_zero;
    logic [4:0] div;

    assign one_req = bus.inc ^ bus.dec;
    // Reload only allowed while the level is below 2.
    assign load    = bus.setval && (value_q < LevelQ2);
    assign run     = bus.ena && one_req && !load;
    assign clr     = bus.ena && (load || !one_req);
    assign div     = bus.fast ? 5'(FAST_DIV) : 5'(SLOW_DIV);

    rate_prescaler u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (run),
        .clr_i  (clr),
        .div_i  (div),
        .tick_o (tick)
    );

    // tick already implies ena and exactly one request.
    assign dec_at_zero = tick && bus.dec && (value_q == 8'd0);

    always_comb begin
        value_d = value_q;
        if (bus.ena) begin
            if (load) begin
                value_d = SET_VALUE;
            end else if (tick) begin
                if (bus.inc) begin
                    if (value_q != 8'hFF) value_d = value_q + 8'd1;
                end else begin
                    if (value_q != 8'h00) value_d = value_q - 8'd1;
                end
            end
        end
        step_d = (value_d != value_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StFed;
            empty_cnt_q <= '0;
            value_q     <= 8'd0;
            step_q      <= 1'b0;
            starving_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            empty_cnt_q <= empty_cnt_d;
            value_q     <= value_d;
            step_q      <= step_d;
            starving_q  <= (state_d == StStarved);
        end
    end

    // Next-state logic; decisions use the value held before this cycle's update.
    always_comb begin
        state_d     = state_q;
        empty_cnt_d = empty_cnt_q;
        if (bus.ena) begin
            unique case (state_q)
                StFed: begin
                    if (dec_at_zero) begin
                        empty_cnt_d = CntW'(1);
                        state_d     = (STARVE_STEPS <= 1) ? StStarved : StEmpty;
                    end
                end
                StEmpty: begin
                    if (value_q != 8'd0) begin
                        empty_cnt_d = '0;
                        state_d     = StFed;
                    end else if (dec_at_zero) begin
                        empty_cnt_d = empty_cnt_q + CntW'(1);
                        if (32'(empty_cnt_q) + 32'd1 >= STARVE_STEPS) state_d = StStarved;
                    end
                end
                StStarved: begin
                    if (value_q >= LevelQ1) begin
                        empty_cnt_d = '0;
                        state_d     = StFed;
                    end
                end
                default: begin
                    empty_cnt_d = '0;
                    state_d     = StFed;
                end
            endcase
        end
    end

    // Outputs, all taken straight from registers
    always_comb begin
        bus.value             = value_q;
        bus.nourishment_level = level_of(value_q);
        bus.step              = step_q;
        bus.starving          = starving_q;
    end

endmodule
